// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: configuration/status bundle for the LED sequencer.
// master drives wren/pattern/len/div/oneshot/en (+duty with LED_PATTERN_PWM_EN)
// and observes led/step/wrap/busy; slave is the sequencer side.
interface led_pattern_gen_if #(parameter int PAT_W = 32);
  localparam int SW = $clog2(PAT_W);
  logic             wren_i;
  logic [PAT_W-1:0] pattern_i;
  logic [4:0]       len_i;
  logic [4:0]       div_i;
  logic             oneshot_i;
  logic             en_i;
`ifdef LED_PATTERN_PWM_EN
  logic [3:0]       duty_i;
`endif
  logic             led_o;
  logic [SW-1:0]    step_o;
  logic             wrap_o;
  logic             busy_o;
`ifdef LED_PATTERN_PWM_EN
  modport master (output wren_i, pattern_i, len_i, div_i, oneshot_i, en_i, duty_i,
                  input led_o, step_o, wrap_o, busy_o);
  modport slave  (input wren_i, pattern_i, len_i, div_i, oneshot_i, en_i, duty_i,
                  output led_o, step_o, wrap_o, busy_o);
`else
  modport master (output wren_i, pattern_i, len_i, div_i, oneshot_i, en_i,
                  input led_o, step_o, wrap_o, busy_o);
  modport slave  (input wren_i, pattern_i, len_i, div_i, oneshot_i, en_i,
                  output led_o, step_o, wrap_o, busy_o);
`endif
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: programmable one-shot/looping LED blink sequencer.
// Ports: clk100, rstn (async active-low), bus (led_pattern_gen_if.slave).
// Optional LED_PATTERN_PWM_EN adds duty_i and a 4-bit PWM gate on led_o.
module led_pattern_gen #(
  parameter int TICK_BASE = 1_000_000,
  parameter int PAT_W     = 32
) (
  input logic               clk100,
  input logic               rstn,
  led_pattern_gen_if.slave  bus
);
  localparam int SW = $clog2(PAT_W);
  localparam int BW = $clog2(TICK_BASE);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [4:0] len_q, len_d, div_q, div_d, scnt_q, scnt_d;
  logic os_q, os_d, loaded_q, loaded_d, led_q, led_d, wrap_q, wrap_d;
  logic [BW-1:0] base_q, base_d;
  logic [SW-1:0] step_q, step_d, len_eff;
  logic run, tick, adv, last, clr, pwm_ok;
`ifdef LED_PATTERN_PWM_EN
  logic [3:0] pwm_q, pwm_d, duty_q, duty_d;
`endif
  assign len_eff = (int'(len_q) >= PAT_W) ? SW'(PAT_W - 1) : SW'(len_q);
  assign run  = state_q == RUN;
  assign tick = run && base_q == BW'(TICK_BASE - 1);
  assign adv  = tick && scnt_q == div_q;
  assign last = step_q == len_eff;
  // A load or a drop to IDLE restarts the sequence from step 0.
  assign clr  = bus.wren_i || state_d == IDLE;
  always_ff @(posedge clk100 or negedge rstn)
    if (!rstn) state_q <= IDLE;
    else state_q <= state_d;
  // en_i low dominates; a load with en_i high always (re)starts RUN.
  always_comb begin
    state_d = state_q;
    if (!bus.en_i) state_d = IDLE;
    else if (bus.wren_i) state_d = RUN;
    else if (state_q == IDLE && loaded_q) state_d = RUN;
    else if (run && adv && last && os_q) state_d = HOLD;
  end
  always_comb begin
    pat_d    = bus.wren_i ? bus.pattern_i : pat_q;
    len_d    = bus.wren_i ? bus.len_i : len_q;
    div_d    = bus.wren_i ? bus.div_i : div_q;
    os_d     = bus.wren_i ? bus.oneshot_i : os_q;
    loaded_d = loaded_q | bus.wren_i;
    base_d   = (clr || tick) ? '0 : run ? base_q + BW'(1) : base_q;
    scnt_d   = (clr || adv) ? '0 : tick ? scnt_q + 5'd1 : scnt_q;
    step_d   = clr ? '0 : !adv ? step_q : !last ? step_q + SW'(1) : os_q ? step_q : '0;
    wrap_d   = !clr && adv && last;
`ifdef LED_PATTERN_PWM_EN
    duty_d   = bus.wren_i ? bus.duty_i : duty_q;
    pwm_d    = state_q != IDLE ? pwm_q + 4'd1 : pwm_q;
    pwm_ok   = pwm_d < duty_d;
`else
    pwm_ok   = 1'b1;
`endif
    // Computed from next-state values so the LED is registered yet tracks the new step.
    led_d    = state_d != IDLE && pat_d[step_d] && pwm_ok;
  end
  always_ff @(posedge clk100 or negedge rstn)
    if (!rstn) begin
      pat_q    <= '0;
      len_q    <= '0;
      div_q    <= '0;
      os_q     <= 1'b0;
      loaded_q <= 1'b0;
      base_q   <= '0;
      scnt_q   <= '0;
      step_q   <= '0;
      wrap_q   <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      pat_q    <= pat_d;
      len_q    <= len_d;
      div_q    <= div_d;
      os_q     <= os_d;
      loaded_q <= loaded_d;
      base_q   <= base_d;
      scnt_q   <= scnt_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      led_q    <= led_d;
    end
`ifdef LED_PATTERN_PWM_EN
  always_ff @(posedge clk100 or negedge rstn)
    if (!rstn) begin
      pwm_q  <= '0;
      duty_q <= '0;
    end else begin
      pwm_q  <= pwm_d;
      duty_q <= duty_d;
    end
`endif
  assign bus.led_o  = led_q;
  assign bus.step_o = step_q;
  assign bus.wrap_o = wrap_q;
  assign bus.busy_o = state_q == RUN;
endmodule
